// File: rtl/mandel_pkg.sv
// Shared types and defaults for the Mandelbrot engine scheduler.
// Coordinate width, frame geometry defaults and scheduler states.
package mandel_pkg;

    localparam int COORD_W    = 11;
    localparam int DEF_X_SIZE = 480;
    localparam int DEF_Y_SIZE = 480;
    localparam int DEF_ITER_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } sched_state_t;

endpackage

// File: rtl/engine_scheduler_coord_counter.sv
// Raster x/y counter: x advances first, wraps to 0 and bumps y.
// last flags the final pixel of the frame at the current position.
module coord_counter
    import mandel_pkg::*;
#(
    parameter int X_SIZE = DEF_X_SIZE,
    parameter int Y_SIZE = DEF_Y_SIZE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               en,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               last
);

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(X_SIZE - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(Y_SIZE - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            x <= '0;
            y <= '0;
        end else if (en) begin
            if (x == X_LAST) begin
                x <= '0;
                y <= (y == Y_LAST) ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    assign last = (x == X_LAST) && (y == Y_LAST);

endmodule

// File: rtl/engine_scheduler.sv
// Round-robin job dispatch to NUM_ENGINES Mandelbrot engines with
// in-order result collection onto an AXI-Stream style pixel output.
module engine_scheduler
    import mandel_pkg::*;
#(
    parameter int NUM_ENGINES = 4,
    parameter int X_SIZE      = DEF_X_SIZE,
    parameter int Y_SIZE      = DEF_Y_SIZE,
    parameter int ITER_W      = DEF_ITER_W
) (
    input  logic                          out_stream_aclk,
    input  logic                          axi_resetn,
    input  logic                          start,
    output logic [NUM_ENGINES-1:0]        eng_req_valid,
    input  logic [NUM_ENGINES-1:0]        eng_req_ready,
    output logic [COORD_W-1:0]            eng_x,
    output logic [COORD_W-1:0]            eng_y,
    input  logic [NUM_ENGINES-1:0]        eng_done,
    input  logic [NUM_ENGINES*ITER_W-1:0] eng_iter,
    output logic [NUM_ENGINES-1:0]        eng_ack,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ITER_W-1:0]             out_iter,
    output logic [COORD_W-1:0]            out_x,
    output logic [COORD_W-1:0]            out_y,
    output logic                          out_sof,
    output logic                          out_eol,
    output logic                          busy,
    output logic                          frame_done
);

    localparam int PTR_W = $clog2(NUM_ENGINES);
    localparam int CNT_W = $clog2(NUM_ENGINES + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(NUM_ENGINES);
    localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(X_SIZE - 1);

    sched_state_t state;
    sched_state_t state_nx;

    logic [PTR_W-1:0]   dptr;
    logic [PTR_W-1:0]   cptr;
    logic [CNT_W-1:0]   outstanding;
    logic [ITER_W-1:0]  iter_sel;
    logic [COORD_W-1:0] coll_x;
    logic [COORD_W-1:0] coll_y;
    logic               disp_last;
    logic               coll_last;
    logic               out_last;
    logic               frame_clr;
    logic               active;
    logic               issue;
    logic               collect;
    logic               hs;

    assign frame_clr = (state == IDLE) && start;
    assign active    = (state == RUN) || (state == DRAIN);
    assign hs        = out_valid && out_ready;

    assign issue = (state == RUN)
                && eng_req_ready[dptr]
                && (outstanding != CNT_MAX);

    // Zero outstanding means any eng_done is stale, never ours to take.
    assign collect = active
                  && eng_done[cptr]
                  && (outstanding != '0)
                  && (!out_valid || out_ready);

    coord_counter #(
        .X_SIZE (X_SIZE),
        .Y_SIZE (Y_SIZE)
    ) u_disp_cnt (
        .clk   (out_stream_aclk),
        .rst_n (axi_resetn),
        .clear (frame_clr),
        .en    (issue),
        .x     (eng_x),
        .y     (eng_y),
        .last  (disp_last)
    );

    coord_counter #(
        .X_SIZE (X_SIZE),
        .Y_SIZE (Y_SIZE)
    ) u_coll_cnt (
        .clk   (out_stream_aclk),
        .rst_n (axi_resetn),
        .clear (frame_clr),
        .en    (collect),
        .x     (coll_x),
        .y     (coll_y),
        .last  (coll_last)
    );

    always_comb begin
        iter_sel = '0;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            if (PTR_W'(i) == cptr) begin
                iter_sel = eng_iter[i*ITER_W +: ITER_W];
            end
        end
    end

    always_comb begin
        eng_req_valid = '0;
        eng_ack       = '0;
        if (issue) begin
            eng_req_valid[dptr] = 1'b1;
        end
        if (collect) begin
            eng_ack[cptr] = 1'b1;
        end
    end

    always_ff @(posedge out_stream_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (issue && disp_last) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (hs && out_last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);

    // Pointers restart at 0 so every frame maps pixel k to engine k mod N.
    always_ff @(posedge out_stream_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            dptr        <= '0;
            cptr        <= '0;
            outstanding <= '0;
        end else begin
            if (frame_clr) begin
                dptr <= '0;
                cptr <= '0;
            end else begin
                if (issue) begin
                    dptr <= dptr + 1'b1;
                end
                if (collect) begin
                    cptr <= cptr + 1'b1;
                end
            end
            if (issue && !collect) begin
                outstanding <= outstanding + 1'b1;
            end else if (!issue && collect) begin
                outstanding <= outstanding - 1'b1;
            end
        end
    end

    always_ff @(posedge out_stream_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            out_valid <= 1'b0;
            out_iter  <= '0;
            out_x     <= '0;
            out_y     <= '0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_last  <= 1'b0;
        end else if (collect) begin
            out_valid <= 1'b1;
            out_iter  <= iter_sel;
            out_x     <= coll_x;
            out_y     <= coll_y;
            out_sof   <= (coll_x == '0) && (coll_y == '0);
            out_eol   <= (coll_x == X_LAST);
            out_last  <= coll_last;
        end else if (hs) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_engine_scheduler.sv
// Scoreboard bench for engine_scheduler with behavioural engine stand-ins
// and a raster-order reference queue.
module tb_engine_scheduler;

    localparam int NE   = 4;
    localparam int XS   = 4;
    localparam int YS   = 2;
    localparam int IW   = 8;
    localparam int CW   = 11;
    localparam int NPIX = XS * YS;

    typedef struct {
        int            x;
        int            y;
        logic [IW-1:0] it;
        bit            sof;
        bit            eol;
    } pix_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic [NE-1:0]    eng_req_valid;
    logic [NE-1:0]    eng_req_ready;
    logic [CW-1:0]    eng_x;
    logic [CW-1:0]    eng_y;
    logic [NE-1:0]    eng_done;
    logic [NE*IW-1:0] eng_iter;
    logic [NE-1:0]    eng_ack;
    logic             out_valid;
    logic             out_ready;
    logic [IW-1:0]    out_iter;
    logic [CW-1:0]    out_x;
    logic [CW-1:0]    out_y;
    logic             out_sof;
    logic             out_eol;
    logic             busy;
    logic             frame_done;

    int n_chk  = 0;
    int n_fail = 0;

    pix_t exp_q[$];
    int   lat[NE];
    bit   rand_lat = 1'b0;
    bit   rdy_mode = 1'b0;
    logic [31:0] lfsr = 32'd1246504138;

    logic          e_busy[NE];
    int            e_cnt[NE];
    logic [IW-1:0] e_res[NE];

    int iss_k, ack_k, outst, hs_f, sof_f, eol_f;
    int cyc = 0, last_hs = 0, fd_count = 0, hs_tot = 0;
    bit pv, pr;
    logic [31:0] pword;

    always #5 clk = ~clk;

    engine_scheduler #(
        .NUM_ENGINES (NE),
        .X_SIZE      (XS),
        .Y_SIZE      (YS),
        .ITER_W      (IW)
    ) dut (
        .out_stream_aclk (clk),
        .axi_resetn      (rst_n),
        .start           (start),
        .eng_req_valid   (eng_req_valid),
        .eng_req_ready   (eng_req_ready),
        .eng_x           (eng_x),
        .eng_y           (eng_y),
        .eng_done        (eng_done),
        .eng_iter        (eng_iter),
        .eng_ack         (eng_ack),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_iter        (out_iter),
        .out_x           (out_x),
        .out_y           (out_y),
        .out_sof         (out_sof),
        .out_eol         (out_eol),
        .busy            (busy),
        .frame_done      (frame_done)
    );

    function automatic logic [IW-1:0] ref_iter(input int x, input int y);
        return IW'((x * 7 + y * 13 + 5) % 256);
    endfunction

    function automatic int oh_idx(input logic [NE-1:0] v);
        for (int i = 0; i < NE; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic chk(input bit ok, input string nm,
                       input longint act, input longint req);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t",
                     nm, act, req, $time);
        end
    endtask

    // Engine stand-ins: accept when idle, hold result until acked.
    always_comb begin
        eng_req_ready = '0;
        eng_done      = '0;
        eng_iter      = '0;
        for (int i = 0; i < NE; i++) begin
            eng_req_ready[i]      = !e_busy[i];
            eng_done[i]           = e_busy[i] && (e_cnt[i] == 0);
            eng_iter[i*IW +: IW]  = e_res[i];
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NE; i++) begin
                e_busy[i] <= 1'b0;
                e_cnt[i]  <= 0;
                e_res[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NE; i++) begin
                if (eng_ack[i]) begin
                    e_busy[i] <= 1'b0;
                end else if (eng_req_valid[i] && !e_busy[i]) begin
                    e_busy[i] <= 1'b1;
                    e_cnt[i]  <= rand_lat ? int'($urandom_range(6, 0)) : lat[i];
                    e_res[i]  <= ref_iter(int'(eng_x), int'(eng_y));
                end else if (e_busy[i] && e_cnt[i] > 0) begin
                    e_cnt[i] <= e_cnt[i] - 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rdy_mode) begin
            out_ready <= lfsr[0];
            lfsr      <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h80200003 : 32'h0);
        end else begin
            out_ready <= 1'b1;
        end
    end

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_k = 0;
            ack_k = 0;
            outst = 0;
            hs_f  = 0;
            sof_f = 0;
            eol_f = 0;
            pv    = 1'b0;
            pr    = 1'b0;
        end else begin
            automatic logic [31:0] cur = {out_x, out_y, out_iter, out_sof, out_eol};
            automatic int i;
            automatic pix_t e;
            cyc++;
            if (pv && !pr) begin
                chk(out_valid && cur == pword, "stall_hold", cur, pword);
            end
            if (eng_req_valid != '0) begin
                i = oh_idx(eng_req_valid);
                chk($onehot(eng_req_valid) && i == iss_k % NE && eng_req_ready[i],
                    "issue_engine", eng_req_valid, 1 << (iss_k % NE));
                chk(int'(eng_x) == iss_k % XS && int'(eng_y) == iss_k / XS
                    && iss_k < NPIX, "issue_coord", {eng_x, eng_y},
                    {CW'(iss_k % XS), CW'(iss_k / XS)});
                iss_k++;
                outst++;
            end
            if (eng_ack != '0) begin
                i = oh_idx(eng_ack);
                chk($onehot(eng_ack) && i == ack_k % NE && eng_done[i],
                    "ack_order", eng_ack, 1 << (ack_k % NE));
                ack_k++;
                outst--;
            end
            if (eng_req_valid != '0 || eng_ack != '0) begin
                chk(outst >= 0 && outst <= NE, "outstanding_range", outst, NE);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_output", cur, 0);
                end else begin
                    automatic logic [31:0] w;
                    e = exp_q.pop_front();
                    w = {CW'(e.x), CW'(e.y), e.it, e.sof, e.eol};
                    chk(cur == w, "out_pixel", cur, w);
                end
                hs_f++;
                hs_tot++;
                if (out_sof) sof_f++;
                if (out_eol) eol_f++;
                last_hs = cyc;
            end
            if (frame_done) begin
                chk(cyc == last_hs + 1, "frame_done_timing", cyc - last_hs, 1);
                chk(hs_f == NPIX, "frame_pixels", hs_f, NPIX);
                chk(sof_f == 1 && eol_f == YS, "sof_eol_count",
                    {sof_f[15:0], eol_f[15:0]}, {16'd1, 16'(YS)});
                chk(outst == 0 && exp_q.size() == 0, "frame_drained",
                    outst, 0);
                fd_count++;
                hs_f  = 0;
                sof_f = 0;
                eol_f = 0;
                iss_k = 0;
                ack_k = 0;
            end
            pv    = out_valid;
            pr    = out_ready;
            pword = cur;
        end
    end

    task automatic chk_reset_vals(input string nm);
        chk({out_valid, out_sof, out_eol, busy, frame_done} == 5'b0,
            nm, {out_valid, out_sof, out_eol, busy, frame_done}, 0);
        chk(out_iter == '0 && out_x == '0 && out_y == '0,
            nm, {out_x, out_y, out_iter}, 0);
        chk(eng_req_valid == '0 && eng_ack == '0,
            nm, {eng_req_valid, eng_ack}, 0);
    endtask

    task automatic push_frame();
        for (int y = 0; y < YS; y++) begin
            for (int x = 0; x < XS; x++) begin
                exp_q.push_back('{x, y, ref_iter(x, y),
                                  (x == 0 && y == 0), (x == XS - 1)});
            end
        end
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_frame(input int budget);
        int snap;
        int n;
        snap = fd_count;
        n = 0;
        while (fd_count == snap && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(fd_count != snap, "frame_timeout", n, budget);
    endtask

    task automatic run_frame(input int budget);
        push_frame();
        pulse_start();
        wait_frame(budget);
    endtask

    initial begin
        int snap;
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        lat   = '{3, 3, 3, 3};
        #2 chk_reset_vals("reset_initial");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        run_frame(400);

        lat = '{2, 20, 2, 2};
        run_frame(800);

        rdy_mode = 1'b1;
        rand_lat = 1'b1;
        repeat (4) run_frame(2000);
        rdy_mode = 1'b0;
        rand_lat = 1'b0;

        lat  = '{3, 3, 3, 3};
        snap = fd_count;
        push_frame();
        pulse_start();
        repeat (3) @(posedge clk);
        #1 chk(busy == 1'b1, "busy_in_frame", busy, 1);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_frame(400);
        repeat (40) @(posedge clk);
        #1 chk(fd_count - snap == 1, "single_frame_done", fd_count - snap, 1);
        chk(busy == 1'b0, "idle_after_frame", busy, 0);

        lat  = '{4, 4, 4, 4};
        snap = hs_tot;
        push_frame();
        pulse_start();
        n = 0;
        while (hs_tot < snap + 5 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(hs_tot >= snap + 5, "five_outputs_timeout", hs_tot - snap, 5);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("reset_midframe");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_frame(400);

        lat = '{3, 2, 1, 0};
        run_frame(400);

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/engine_scheduler.md
ENGINE_SCHEDULER -- requirements
Module: engine_scheduler

Interface
REQ-001 Parameter NUM_ENGINES, default 4, number of Mandelbrot engines scheduled (power of 2, 2..16).
REQ-002 Parameter X_SIZE, default 480, pixels per line.
REQ-003 Parameter Y_SIZE, default 480, lines per frame.
REQ-004 Parameter ITER_W, default 8, iteration-count width.
REQ-005 out_stream_aclk  in  1  sole clock; all logic on its rising edge.
REQ-006 axi_resetn  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  single-cycle pulse that begins one frame.
REQ-008 eng_req_valid  out  NUM_ENGINES  one-hot job issue to engine i.
REQ-009 eng_req_ready  in  NUM_ENGINES  engine i idle and able to accept a job.
REQ-010 eng_x / eng_y  out  11 / 11  broadcast pixel coordinate for the issued job.
REQ-011 eng_done  in  NUM_ENGINES  engine i holds a finished result.
REQ-012 eng_iter  in  NUM_ENGINES*ITER_W  packed results, engine i at slice [i*ITER_W +: ITER_W].
REQ-013 eng_ack  out  NUM_ENGINES  one-hot; the result of engine i has been taken.
REQ-014 out_valid / out_ready  out / in  1 / 1  result-stream handshake.
REQ-015 out_iter  out  ITER_W  iteration count of the current output pixel.
REQ-016 out_x / out_y  out  11 / 11  coordinate of the current output pixel.
REQ-017 out_sof / out_eol  out  1 / 1  first pixel of frame / last pixel of line.
REQ-018 busy  out  1  high while in any state except IDLE.
REQ-019 frame_done  out  1  single-cycle pulse after the last pixel handshakes.

Function
REQ-020 The FSM has states IDLE, RUN, DRAIN and DONE. Transitions: IDLE->RUN on start; RUN->DRAIN when the final pixel (X_SIZE-1, Y_SIZE-1) is issued; DRAIN->DONE when the final output handshakes; DONE->IDLE unconditionally after one cycle.
REQ-021 Pixels are issued in raster order: x increments first, wraps X_SIZE-1->0 with y+1.
REQ-022 Pixel k goes to engine (k mod NUM_ENGINES) via dispatch pointer dptr; no other engine is ever chosen.
REQ-023 In RUN, eng_req_valid[dptr] is asserted combinationally when eng_req_ready[dptr] is high. Issue completes in that cycle; dptr and the coordinate advance on the next edge. At most one issue per cycle.
REQ-024 Results are collected in order via collect pointer cptr, using the same modulo sequence; output order therefore equals raster order.
REQ-025 The output register loads when eng_done[cptr] is high and (out_valid is low or out_ready is high). eng_ack[cptr] is pulsed in that same cycle, and cptr advances.
REQ-026 Latency from eng_done[cptr] to out_valid is 1 cycle; sustained throughput is 1 pixel/cycle when engines keep up.
REQ-027 out_valid, once high, holds with out_iter, out_x, out_y, out_sof and out_eol stable until out_ready (AXI-Stream rule).
REQ-028 out_sof is high only with out_x=0 and out_y=0; out_eol is high only with out_x=X_SIZE-1.
REQ-029 An outstanding-job counter ranges 0..NUM_ENGINES: +1 on issue, -1 on ack, unchanged when both happen in the same cycle. Issue is blocked at NUM_ENGINES.
REQ-030 The same engine may be acked and re-issued in one cycle only if it already shows eng_req_ready.
REQ-031 start is ignored outside IDLE.
REQ-032 eng_done on an engine other than eng_done[cptr] is held off (no ack) until cptr reaches it.

Reset
REQ-033 Asserting axi_resetn low at any time, including mid-frame, immediately forces: state=IDLE, dptr=cptr=0, counters 0, out_valid=0, out_iter/out_x/out_y=0, out_sof=out_eol=0, busy=0, frame_done=0, eng_req_valid=0, eng_ack=0.
REQ-034 After reset release, the first start begins a fresh frame at (0,0); in-flight engine results from the aborted frame are the engines' responsibility to flush.

Structure
REQ-035 Package mandel_pkg holds COORD_W=11, the sched_state_t enum, and the default X_SIZE, Y_SIZE, ITER_W values.
REQ-036 Sub-module coord_counter (raster x/y counter with enable, wrap, and last flag) is instantiated twice: once for dispatch and once for output.

Verification
REQ-037 Directed scenarios:
- X_SIZE=4, Y_SIZE=2, engines always ready, fixed 3-cycle compute, out_ready=1: start -> 8 outputs in order; sof on (0,0); eol on x=3; frame_done 1 cycle after the 8th handshake.
- Engine 1 takes 20 cycles, others take 2: start -> the output for pixel 2 never precedes pixel 1; engine 2 is not acked before engine 1.
- out_ready toggling 50% (PRBS seed 1246504138): out_* stable while stalled; exactly X_SIZE*Y_SIZE handshakes; one sof; Y_SIZE eols.
- start pulsed during RUN -> ignored; pixel count unchanged; single frame_done.
- axi_resetn dropped after 5 outputs -> all outputs reach reset values in the same cycle; next start restarts at (0,0) with sof.
- All engines done in the same cycle, out_ready=1 -> acks issued one per cycle in order 0,1,2,3; outstanding count returns to 0.
